uart_tx: RTL and testbench

Buffered 8N1 UART transmitter: accepts bytes over a valid/ready handshake into an internal FIFO and serialises them LSB-first onto the `tx` line at a fixed baud rate. It is the transmit counterpart of the design's UART receiver and drives the FTDI RX pin, returning results (e.g. sorted data) to the host. Back-to-back frames are sent with no idle gap while the FIFO holds data.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_tx_fifo.sv | 59 +++++
 rtl/uart_tx.sv | 129 ++++++++++++
 tb/tb_uart_tx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and the baud divisor helper.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // Clock cycles per bit, truncating.
  function automatic int baud_cnt(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO feeding the transmitter; show-ahead read of the head entry.
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Push is gated by full alone, so a pop in the same cycle cannot free a slot early.
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: FIFO in front of a start/data/stop serialiser.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             data_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int BC   = baud_cnt(CLK_FREQ, BAUD);
  localparam int CNTW = (BC > 1) ? $clog2(BC) : 1;
  localparam logic [CNTW-1:0] RELOAD = CNTW'(BC - 1);

  tx_state_t       state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            pop, full, empty;
  logic [7:0]      head;

  uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (valid_in && ready_out),
    .pop   (pop),
    .wdata (data_in),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign ready_out = !full;
  assign tx        = tx_q;
  assign busy      = busy_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          cnt_d   = RELOAD;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          cnt_d     = RELOAD;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = RELOAD;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      STOP: begin
        // Chain straight into the next start bit when more data is waiting.
        if (cnt_q == '0) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            cnt_d   = RELOAD;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line and busy are registered from current state, so both trail the FSM by one cycle.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[bit_idx_q];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_q != IDLE) || (fifo_count != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: scoreboard of accepted bytes checked against decoded frames.
module tb_uart_tx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DEPTH    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out, tx, busy;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] sb[$];

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a byte and hold valid until the edge that accepts it; valid stays high on return.
  task automatic push(input logic [7:0] b, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    data_in  = b;
    valid_in = 1'b1;
    while (ready_out !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", {31'd0, ready_out}, 1);
    @(posedge clk);
    #1;
    acc = cyc;
    sb.push_back(b);
  endtask

  // Decode one frame; each bit is sampled at its first and last cycle.
  task automatic rx_frame(output logic [7:0] b, output int fall);
    int n, glitches;
    logic a0, a9;
    logic [9:0] bits;
    logic [7:0] exp;
    n = 0; glitches = 0; b = 8'h00; fall = 0; bits = '0;
    @(negedge clk);
    while (tx !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("rx_start_seen", {31'd0, tx}, 0);
    if (tx !== 1'b0) return;
    fall = cyc;
    for (int i = 0; i < 10; i++) begin
      a0 = tx;
      repeat (9) @(negedge clk);
      a9 = tx;
      if (a0 !== a9) glitches++;
      bits[i] = a0;
      if (i < 9) @(negedge clk);
    end
    chk("rx_bit_stable", glitches, 0);
    chk("rx_stop_bit", {31'd0, bits[9]}, 1);
    b = bits[8:1];
    if (sb.size() == 0) chk("rx_unexpected_frame", sb.size(), 1);
    else begin
      exp = sb.pop_front();
      chk("rx_byte", {24'd0, b}, {24'd0, exp});
    end
  endtask

  initial begin
    int a1, a2, a3, a4, a5, a6, f1, f2, bad, n;
    logic [7:0] rb;

    // Reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx",    {31'd0, tx}, 1);
    chk("rst_busy",  {31'd0, busy}, 0);
    chk("rst_ready", {31'd0, ready_out}, 1);
    chk("rst_count", {29'd0, fifo_count}, 0);
    rst = 1'b0;

    // Idle hold
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("idle_hold", bad, 0);

    // Single byte 0xA5
    push(8'hA5, a1);
    valid_in = 1'b0;
    @(negedge clk);
    chk("single_busy_e0", {31'd0, busy}, 0);
    chk("single_count_e0", {29'd0, fifo_count}, 1);
    @(negedge clk);
    chk("single_tx_e1", {31'd0, tx}, 1);
    chk("single_busy_e1", {31'd0, busy}, 1);
    chk("single_count_e1", {29'd0, fifo_count}, 0);
    rx_frame(rb, f1);
    chk("single_latency", f1 - a1, 2);
    chk("single_busy_e101", {31'd0, busy}, 1);
    @(negedge clk);
    chk("single_busy_e102", {31'd0, busy}, 0);
    chk("single_busy_fall_cycle", cyc - a1, 102);

    // Back-to-back 0x00, 0xFF
    repeat (20) @(negedge clk);
    push(8'h00, a1);
    push(8'hFF, a2);
    valid_in = 1'b0;
    chk("b2b_consecutive", a2 - a1, 1);
    chk("b2b_count", {29'd0, fifo_count}, 1);
    rx_frame(rb, f1);
    rx_frame(rb, f2);
    chk("b2b_latency", f1 - a1, 2);
    chk("b2b_gap", f2 - f1, 100);
    @(negedge clk);
    chk("b2b_busy_end", {31'd0, busy}, 0);

    // FIFO full with six bytes offered back to back
    repeat (20) @(negedge clk);
    fork
      begin
        push(8'h11, a1);
        push(8'h12, a2);
        push(8'h13, a3);
        push(8'h14, a4);
        push(8'h15, a5);
        @(negedge clk);
        chk("full_ready", {31'd0, ready_out}, 0);
        chk("full_count", {29'd0, fifo_count}, 4);
        chk("full_accepts", a5 - a1, 4);
        push(8'h16, a6);
        valid_in = 1'b0;
        chk("full_refill_time", a6 - a1, 102);
      end
      begin
        for (int i = 0; i < 6; i++) rx_frame(rb, f2);
      end
    join
    chk("full_sb_drained", sb.size(), 0);
    @(negedge clk);
    chk("full_busy_end", {31'd0, busy}, 0);

    // Reset during bit 4 of 0x3C with two bytes queued
    repeat (20) @(negedge clk);
    push(8'h3C, a1);
    push(8'h01, a2);
    push(8'h02, a3);
    valid_in = 1'b0;
    n = 0;
    @(negedge clk);
    while (tx !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_start_seen", {31'd0, tx}, 0);
    repeat (43) @(negedge clk);
    chk("mid_count_pre", {29'd0, fifo_count}, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_tx", {31'd0, tx}, 1);
    chk("mid_rst_count", {29'd0, fifo_count}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    sb.delete();
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) bad++;
    end
    chk("mid_no_frames", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
